// File: rtl/spi_pkg.sv
// Shared definitions for the SPI daisy-chain master.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        DONE
    } spi_mst_state_t;

endpackage

// File: rtl/spi_daisy_master_timer.sv
// Phase timer: tick marks the last cycle of a CLK_DIV-cycle phase.
module spi_phase_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign tick = (div_cnt_q == LAST);

    // Wrap explicitly on tick so non-power-of-two dividers restart at 0.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (restart || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_daisy_master.sv
// Mode-0 SPI master shifting one 8*N_SLAVES-bit frame through a slave daisy chain.
module spi_daisy_master
    import spi_pkg::*;
#(
    parameter int unsigned N_SLAVES = 3,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [SPI_WORD_W*N_SLAVES-1:0]   tx_data,
    output logic                             busy,
    output logic                             done,
    output logic [SPI_WORD_W*N_SLAVES-1:0]   rx_data,
    output logic                             sclk,
    output logic                             ss,
    output logic                             mosi,
    input  logic                             miso
);

    localparam int unsigned FRAME_W = SPI_WORD_W * N_SLAVES;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    spi_mst_state_t     state_q, state_d;
    logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               sclk_q, sclk_d;
    logic               ss_q, ss_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic tick;
    logic restart;

    // Every other state transition happens on tick, which self-clears the timer.
    assign restart = (state_q == IDLE) || (state_q == DONE);

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sh_d   = tx_data;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SCLK_HI;
                end
            end
            SCLK_HI: begin
                if (tick) begin
                    rx_sh_d   = {rx_sh_q[FRAME_W-2:0], miso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        state_d = SCLK_LO;
                    end
                end
            end
            SCLK_LO: begin
                if (tick) begin
                    state_d = SCLK_HI;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        sclk_d = (state_d == SCLK_HI);
        ss_d   = !(state_d inside {SETUP, SCLK_HI, SCLK_LO, HOLD});
        mosi_d = (state_d inside {SETUP, SCLK_HI, SCLK_LO}) ? tx_sh_d[FRAME_W-1] : 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == DONE) begin
            rx_data_d = rx_sh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sclk    = sclk_q;
    assign ss      = ss_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_daisy_master.sv
// Self-checking bench for spi_daisy_master: frame vectors, scoreboard and corner-case sequences.
module tb_spi_daisy_master;

    localparam int FW  = 24;
    localparam int LAT = 197;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] tx_data;
    logic [FW-1:0] rx_data;
    logic          busy, done, sclk, ss, mosi, miso;
    int            miso_mode;

    logic          start2;
    logic [7:0]    tx2, rx2;
    logic          busy2, done2, sclk2, ss2, mosi2;

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    spi_daisy_master #(.N_SLAVES(3), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_daisy_master #(.N_SLAVES(1), .CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .busy(busy2), .done(done2), .rx_data(rx2),
        .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(mosi2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running monitors; sequences take deltas against snapshots.
    logic        sclk_prev = 1'b0;
    int          edges = 0, ones = 0, dones = 0;
    logic [31:0] mosi_hist = '0;
    always @(negedge clk) begin
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            edges++;
            mosi_hist = {mosi_hist[30:0], mosi};
            if (mosi === 1'b1) ones++;
        end
        sclk_prev = sclk;
        if (done === 1'b1) dones++;
    end

    logic [FW-1:0] sb_q[$];
    logic [7:0]    sb2_q[$];

    typedef struct {
        logic [FW-1:0] tx;
        int            mode;
        logic [FW-1:0] exp_rx;
    } vec_t;
    vec_t vecs[5];

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick_n();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"},   {31'd0, ss},   32'd1);
        check({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
        check({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rx"},   {8'd0, rx_data}, 32'd0);
    endtask

    task automatic run_frame(input logic [FW-1:0] tx, input int mode, input logic [FW-1:0] exp_rx);
        int t0, e0, o0;
        bit seen;
        logic [FW-1:0] exp;
        miso_mode = mode;
        tick_n();
        tx_data = tx;
        start   = 1'b1;
        sb_q.push_back(exp_rx);
        t0 = cyc; e0 = edges; o0 = ones;
        tick_n();
        start = 1'b0;
        wait_done(2000, seen);
        check("frame_done_seen", {31'd0, seen}, 32'd1);
        if (!seen) begin
            void'(sb_q.pop_front());
            return;
        end
        exp = sb_q.pop_front();
        check("frame_rx", {8'd0, rx_data}, {8'd0, exp});
        check("frame_latency", cyc - t0, LAT);
        check("frame_sclk_edges", edges - e0, FW);
        check("frame_mosi_seq", {8'd0, mosi_hist[FW-1:0]}, {8'd0, tx});
        check("frame_mosi_ones", ones - o0, $countones(tx));
        check("frame_busy_at_done", {31'd0, busy}, 32'd1);
        tick_n();
        check("frame_done_width", {31'd0, done}, 32'd0);
        check("frame_busy_after", {31'd0, busy}, 32'd0);
        check("frame_ss_after", {31'd0, ss}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int t0, e0, d0, done_at, gap;
        bit seen;
        logic [FW-1:0] rx_cap;

        vecs[0] = '{24'hA5_3C_F0, 0, 24'hA5_3C_F0};
        vecs[1] = '{24'h00_0000, 1, 24'hFF_FFFF};
        vecs[2] = '{24'h00_0000, 2, 24'h00_0000};
        vecs[3] = '{24'h5A_0F_81, 0, 24'h5A_0F_81};
        vecs[4] = '{24'hFF_FFFF, 2, 24'h00_0000};

        rst = 1'b1; start = 1'b0; tx_data = '0; miso_mode = 2;
        start2 = 1'b0; tx2 = '0;
        repeat (3) tick_n();
        rst = 1'b0;
        check_reset_outputs("por");

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].tx, vecs[i].mode, vecs[i].exp_rx);
        end

        // start at cycles 0, 50 and 197 (DONE): only the first may launch a frame
        miso_mode = 0;
        tick_n();
        t0 = cyc; d0 = dones; e0 = edges; done_at = -1; rx_cap = '0;
        sb_q.push_back(24'h3C_A5_96);
        for (int i = 0; i < 600; i++) begin
            if (i == 0 || i == 50 || i == 197) begin
                tx_data = (i == 0) ? 24'h3C_A5_96 : ((i == 50) ? 24'h11_1111 : 24'h22_2222);
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick_n();
            if (done === 1'b1) begin
                done_at = cyc - t0;
                rx_cap  = rx_data;
            end
        end
        check("ignore_done_count", dones - d0, 1);
        check("ignore_done_at", done_at, LAT);
        check("ignore_rx", {8'd0, rx_cap}, {8'd0, sb_q.pop_front()});
        check("ignore_sclk_edges", edges - e0, FW);
        check("ignore_mosi_seq", {8'd0, mosi_hist[FW-1:0]}, 32'h3C_A596);

        // start held high across two frames
        miso_mode = 0;
        tick_n();
        d0 = dones;
        tx_data = 24'h00_0001;
        start   = 1'b1;
        sb_q.push_back(24'h00_0001);
        sb_q.push_back(24'h80_0000);
        wait_done(2000, seen);
        check("b2b_first_done", {31'd0, seen}, 32'd1);
        tx_data = 24'h80_0000;
        check("b2b_first_rx", {8'd0, rx_data}, {8'd0, sb_q.pop_front()});
        check("b2b_first_mosi", {8'd0, mosi_hist[FW-1:0]}, 32'h00_0001);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            if (ss !== 1'b1) break;
            gap++;
            tick_n();
        end
        check("b2b_gap_ge2", {31'd0, gap >= 2}, 32'd1);
        check("b2b_second_started", {31'd0, ss}, 32'd0);
        start = 1'b0;
        wait_done(2000, seen);
        check("b2b_second_done", {31'd0, seen}, 32'd1);
        check("b2b_second_rx", {8'd0, rx_data}, {8'd0, sb_q.pop_front()});
        check("b2b_second_mosi", {8'd0, mosi_hist[FW-1:0]}, 32'h80_0000);
        repeat (50) tick_n();
        check("b2b_done_count", dones - d0, 2);

        // reset during bit 10 aborts the frame
        miso_mode = 0;
        tick_n();
        tx_data = 24'h12_3456;
        start   = 1'b1;
        e0 = edges; d0 = dones;
        tick_n();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (edges - e0 >= 10) begin
                seen = 1'b1;
                break;
            end
            tick_n();
        end
        check("abort_reached_bit10", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        repeat (3) tick_n();
        rst = 1'b0;
        check_reset_outputs("abort");
        e0 = edges;
        repeat (400) tick_n();
        check("abort_no_done", dones - d0, 0);
        check("abort_no_edges", edges - e0, 0);

        // N_SLAVES=1, CLK_DIV=2 instance
        begin
            int edges2, last_edge, per_bad;
            logic prev2;
            logic [7:0] hist2;
            tick_n();
            tx2 = 8'h81;
            start2 = 1'b1;
            sb2_q.push_back(8'h81);
            t0 = cyc;
            tick_n();
            start2 = 1'b0;
            edges2 = 0; last_edge = -1; per_bad = 0; prev2 = 1'b0; hist2 = '0;
            done_at = -1; rx_cap = '0;
            for (int i = 0; i < 200; i++) begin
                if (sclk2 === 1'b1 && prev2 === 1'b0) begin
                    edges2++;
                    hist2 = {hist2[6:0], mosi2};
                    if (last_edge >= 0 && (cyc - last_edge) != 4) per_bad++;
                    last_edge = cyc;
                end
                prev2 = sclk2;
                if (done2 === 1'b1) begin
                    done_at = cyc - t0;
                    rx_cap  = {16'd0, rx2};
                    break;
                end
                tick_n();
            end
            check("sweep_done_at", done_at, 35);
            check("sweep_rx", {8'd0, rx_cap}, {24'd0, sb2_q.pop_front()});
            check("sweep_sclk_edges", edges2, 8);
            check("sweep_period_bad", per_bad, 0);
            check("sweep_mosi_seq", {24'd0, hist2}, 32'h81);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_daisy_master.md
Name: spi_daisy_master

Overview:
SPI master that drives one daisy chain of N_SLAVES byte-wide SPI slaves sharing a single ss line. It sits directly upstream of the slave chain and generates sclk, ss and mosi. It shifts out one frame of 8*N_SLAVES bits, MSB first, and captures the same number of bits from the chain's final miso. The system side uses a start/busy/done handshake with parallel frame buses.

Parameters:
- N_SLAVES, 3, number of 8-bit slaves in the chain; frame length FRAME_W = 8*N_SLAVES bits.
- CLK_DIV, 4, clk cycles per sclk half-period; legal range is CLK_DIV >= 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to send one frame; honoured only in IDLE.
- tx_data  input  FRAME_W  frame to send; bit FRAME_W-1 is sent first. Sampled only on the cycle start is accepted.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
- done  output  1  one-cycle pulse at the end of the frame.
- rx_data  output  FRAME_W  captured frame; the first captured bit is the MSB. Updates only in the DONE cycle and holds otherwise.
- sclk  output  1  SPI clock, mode 0 (idles low).
- ss  output  1  active-low chain select.
- mosi  output  1  serial data to the first slave.
- miso  input  1  serial data from the last slave; ignored while ss=1.

Behaviour:
- Reset: when rst=1 at a clk edge, the next cycle has sclk=0, ss=1, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately to the reset values. No done pulse is issued and rx_data reads 0.
- State machine states: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE. Shared type spi_mst_state_t.
- IDLE:
  - Outputs are ss=1, sclk=0, mosi=0.
  - If start=1: load tx_data into tx_sh, clear rx_sh, clear bit_cnt, go to SETUP.
- SETUP (CLK_DIV cycles):
  - ss=0, sclk=0, mosi=tx_sh[FRAME_W-1].
  - Then go to SCLK_HI.
- SCLK_HI (CLK_DIV cycles):
  - sclk=1, mosi held.
  - On the last cycle of the phase: rx_sh <= {rx_sh[FRAME_W-2:0], miso} and bit_cnt++.
  - If bit_cnt was FRAME_W-1, go to HOLD; otherwise go to SCLK_LO.
- SCLK_LO (CLK_DIV cycles):
  - sclk=0.
  - On entry, tx_sh shifts left by 1, so mosi presents the next bit, changing coincident with the falling sclk edge.
  - Then go to SCLK_HI.
- HOLD (CLK_DIV cycles):
  - sclk=0, ss=0, mosi=0.
  - Then go to DONE.
- DONE (1 cycle):
  - ss=1, done=1, busy=1, rx_data <= rx_sh.
  - Then go to IDLE.
- Phase timing uses a div_cnt of width $clog2(CLK_DIV). It resets to 0 on every state entry; the phase ends when div_cnt == CLK_DIV-1.
- bit_cnt has width $clog2(FRAME_W+1).
- Latency: start accepted at cycle 0 gives done=1 at cycle 1 + CLK_DIV + 2*CLK_DIV*FRAME_W. For the defaults that is cycle 197.
- Exactly FRAME_W rising sclk edges per frame. No sclk edges occur while ss=1.
- start while not in IDLE, including the DONE cycle, is ignored and not queued.
- start=1 held continuously: the next frame begins at the first IDLE cycle, so each frame is followed by at least one ss=1 IDLE cycle plus the DONE cycle.
- All outputs are registered; none is combinational from inputs.

Decomposition:
- Package spi_pkg holds:
  - SPI_WORD_W = 8;
  - typedef enum logic [2:0] spi_mst_state_t {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE}.
- Sub-module spi_phase_timer(clk, rst, restart, tick):
  - Parameter CLK_DIV.
  - tick pulses on the last cycle of each phase; restart clears the count.
  - The master FSM instantiates it once.

Test Plan:
- Reset check: rst high for 3 cycles mid-frame (during bit 10). The cycle after reset shows ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0. No done pulse ever follows.
- Loopback, defaults: miso tied to mosi, tx_data=24'hA5_3C_F0, start at cycle 0. Required: done at cycle 197, rx_data=24'hA5_3C_F0, 24 rising sclk edges, mosi sequence 1010_0101_0011_1100_1111_0000.
- Constant miso: miso=1, tx_data=0. Required: rx_data=24'hFF_FFFF and mosi=0 throughout. Repeat with miso=0: rx_data=0.
- Busy-ignore: start pulsed at cycles 0, 50 and 197 (DONE cycle) with differing tx_data. Required: only one frame is sent, carrying the cycle-0 data, and exactly one done pulse.
- Back-to-back: start held high, tx_data=24'h000001 then 24'h800000. Required: two frames with ss=1 for at least 2 cycles between them. Loopback rx_data matches each frame in turn.
- Parameter sweep: N_SLAVES=1, CLK_DIV=2, tx_data=8'h81, loopback. Required: done at cycle 1+2+32=35, rx_data=8'h81, sclk period 4 clk.
